// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants, types and helpers for the multi-channel
//                clock-enable generator (clk_div_multi / clk_div_chan).
//                  CLK_DIV_DEFAULT : reset divide ratio (1 Hz at 100 MHz)
//                  CLK_DIV_WIDTH   : default ratio / counter width
//                  div_t           : ratio type at the default width
//                  ch_w(n)         : channel-select width, max(1, clog2(n))
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 100_000_000;
    localparam int unsigned CLK_DIV_WIDTH   = 28;

    typedef logic [CLK_DIV_WIDTH-1:0] div_t;

    // A single channel still needs a one-bit select port.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel. Counts 0..d-1 while enabled and emits a
//                registered one-cycle tick per period. New ratios are held in
//                a shadow register and applied only at a period boundary
//                (wrap cycle) or while the channel is disabled.
//                Optional square-wave output is built only when the macro
//                CLK_DIV_SQUARE_EN is defined; otherwise sq is tied to 0.
//  Ports       : sysclk  - clock (rising edge)
//                reset   - asynchronous active-high reset
//                en      - run enable
//                cfg_we  - write strobe for this channel
//                cfg_div - new divide ratio
//                tick    - one-cycle pulse per period (registered)
//                sq      - square wave (registered, or constant 0)
//                pend    - a written ratio is waiting for a boundary
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      WIDTH       = CLK_DIV_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(CLK_DIV_DEFAULT)
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             tick,
    output logic             sq,
    output logic             pend
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_TWO = WIDTH'(2);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] sdw_q, sdw_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] eff_div;
    logic             at_last;
    logic             boundary;
    logic             apply;

    always_comb begin
        // Ratios 0 and 1 both mean "tick every cycle".
        eff_div  = (div_q < C_TWO) ? C_ONE : div_q;
        at_last  = (cnt_q == (eff_div - C_ONE));
        // Safe points to swap the ratio: end of a running period, or any
        // cycle in which the channel is stopped.
        boundary = at_last || !en;
        tick_d   = en && at_last;

        cnt_d  = cnt_q;
        div_d  = div_q;
        sdw_d  = sdw_q;
        pend_d = pend_q;
        apply  = 1'b0;

        if (en) begin
            cnt_d = at_last ? '0 : (cnt_q + C_ONE);
        end

        if (cfg_we) begin
            sdw_d = cfg_div;
            if (boundary) begin
                // Write lands on a boundary: take it now, never pend.
                apply  = 1'b1;
                div_d  = cfg_div;
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end else if (boundary && pend_q) begin
            apply  = 1'b1;
            div_d  = sdw_q;
            pend_d = 1'b0;
        end

        // A freshly applied ratio always starts a clean period.
        if (apply) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= DEFAULT_DIV;
            sdw_q  <= DEFAULT_DIV;
            pend_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            sdw_q  <= sdw_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
    assign pend = pend_q;

`ifdef CLK_DIV_SQUARE_EN
    logic sq_q, sq_d;
    logic at_half;

    // sq rises at the period start (after cnt == d-1) and falls after
    // cnt == (d>>1)-1, so it is high for floor(d/2) cycles of each period.
    always_comb begin
        at_half = (cnt_q == ((eff_div >> 1) - C_ONE));
        sq_d    = sq_q;
        if (en && (eff_div != C_ONE)) begin
            if (at_last) begin
                sq_d = 1'b1;
            end else if (at_half) begin
                sq_d = 1'b0;
            end
        end
        if (apply) begin
            sq_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`else
    assign sq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_multi
//  Description : Multi-channel clock-enable generator. Decodes the shared
//                configuration port into per-channel write strobes and
//                instantiates NCH independent clk_div_chan dividers.
//                Square-wave outputs exist only when CLK_DIV_SQUARE_EN is
//                defined; otherwise sq is constant 0.
//  Ports       : sysclk  - clock (rising edge)
//                reset   - asynchronous active-high reset
//                en      - per-channel run enable [NCH]
//                cfg_we  - one-cycle ratio write strobe
//                cfg_ch  - target channel (values >= NCH ignored)
//                cfg_div - new divide ratio [WIDTH]
//                tick    - per-channel one-cycle period pulse [NCH]
//                sq      - per-channel square wave [NCH]
//                pend    - per-channel ratio-write-pending flag [NCH]
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned      NCH         = 4,
    parameter int unsigned      WIDTH       = CLK_DIV_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(CLK_DIV_DEFAULT)
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic [NCH-1:0]         en,
    input  logic                   cfg_we,
    input  logic [ch_w(NCH)-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]       cfg_div,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         sq,
    output logic [NCH-1:0]         pend
);

    localparam int unsigned CH_W = ch_w(NCH);

    logic [NCH-1:0] we_ch;

    // Only indices 0..NCH-1 are decoded, so out-of-range selects hit nothing.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign we_ch[g] = cfg_we && (cfg_ch == CH_W'(g));

        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .sysclk  (sysclk),
            .reset   (reset),
            .en      (en[g]),
            .cfg_we  (we_ch[g]),
            .cfg_div (cfg_div),
            .tick    (tick[g]),
            .sq      (sq[g]),
            .pend    (pend[g])
        );
    end

endmodule
`default_nettype wire
